debounce_multi: RTL and testbench

Multi-channel, parametrised debouncer for buttons, switches and other slow, noisy external inputs. It synchronises each input bit, then filters it either by requiring the input to be stable for a set window or by a lockout after each accepted edge. It outputs a clean level plus one-cycle rise and fall pulses per channel, and an aggregate change strobe for interrupt or event logic. It sits directly behind the GPIO pads, ahead of any software-visible input register.

---
 rtl/debounce_multi_if.sv | 14 +
 rtl/debounce_multi.sv | 121 ++++++++++++
 tb/tb_debounce_multi.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Signal bundle for the multi-channel debouncer: raw pad inputs in, filtered levels and event pulses out.
interface debounce_multi_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] long;
    logic             any_change;

    modport master (output in, input out, rise, fall, long, any_change);
    modport slave  (input in, output out, rise, fall, long, any_change);
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: 2-flop synchroniser, then stable-window (MODE 0) or lockout (MODE 1) filter.
// Define DEBOUNCE_MULTI_LONGPRESS_EN to build per-channel long-press detection on bus.long.
module debounce_multi #(
    parameter int               WIDTH     = 8,
    parameter int               DELAY_CNT = 128,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter int               LONG_CNT  = 1000000
) (
    input logic             clk,
    input logic             resetn,
    debounce_multi_if.slave bus
);
    localparam int            CW   = (DELAY_CNT > 1) ? $clog2(DELAY_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DELAY_CNT - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] acc;
    logic             any_q;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];

    // acc[i] marks a channel whose synchronised input is accepted this cycle
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (MODE == 0) begin
                if (s2[i] == out_q[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == LAST) begin
                    acc[i]     = 1'b1;
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end else begin
                if (cnt[i] != '0) begin
                    cnt_nxt[i] = cnt[i] - 1'b1;
                end else if (s2[i] != out_q[i]) begin
                    acc[i]     = 1'b1;
                    cnt_nxt[i] = LAST;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1     <= INIT;
            s2     <= INIT;
            out_q  <= INIT;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= bus.in;
            s2     <= s1;
            out_q  <= out_q ^ acc;
            rise_q <= acc & s2;
            fall_q <= acc & ~s2;
            any_q  <= |acc;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign bus.out        = out_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.any_change = any_q;

`ifdef DEBOUNCE_MULTI_LONGPRESS_EN
    localparam int            HW    = $clog2(LONG_CNT);
    localparam logic [HW-1:0] HLAST = HW'(LONG_CNT - 1);

    logic [HW-1:0]    hold [WIDTH];
    logic [WIDTH-1:0] fired;
    logic [WIDTH-1:0] long_q;

    // Any accepted edge re-arms; after firing, 'fired' holds the channel saturated until the next edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fired  <= '0;
            long_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            long_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (acc[i]) begin
                    hold[i]  <= '0;
                    fired[i] <= 1'b0;
                end else if (out_q[i] && !fired[i]) begin
                    if (hold[i] == HLAST) begin
                        long_q[i] <= 1'b1;
                        fired[i]  <= 1'b1;
                    end else begin
                        hold[i] <= hold[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.long = long_q;
`else
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_CNT >= 2);
    assign bus.long        = '0;
`endif
endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: three configurations checked every cycle against a window/lockout model.
module tb_debounce_multi;
    localparam int W  = 4;
    localparam int LC = 8;
`ifdef DEBOUNCE_MULTI_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    debounce_multi_if #(.WIDTH(W)) b0 ();
    debounce_multi_if #(.WIDTH(W)) b1 ();
    debounce_multi_if #(.WIDTH(W)) b2 ();

    debounce_multi #(.WIDTH(W), .DELAY_CNT(4), .MODE(0), .INIT(4'b0101), .LONG_CNT(LC))
        u0 (.clk(clk), .resetn(resetn), .bus(b0.slave));
    debounce_multi #(.WIDTH(W), .DELAY_CNT(4), .MODE(1), .INIT(4'b0000), .LONG_CNT(LC))
        u1 (.clk(clk), .resetn(resetn), .bus(b1.slave));
    debounce_multi #(.WIDTH(W), .DELAY_CNT(1), .MODE(0), .INIT(4'b0000), .LONG_CNT(LC))
        u2 (.clk(clk), .resetn(resetn), .bus(b2.slave));

    always #5 clk = ~clk;

    // Model: acceptance decided from a window of past synchronised samples and time since last edge
    int           d_cfg    [3] = '{4, 4, 1};
    int           m_cfg    [3] = '{0, 1, 0};
    logic [W-1:0] init_cfg [3] = '{4'b0101, 4'b0000, 4'b0000};
    logic [W-1:0] pipe  [3][2];
    logic [W-1:0] hist  [3][8];
    int           since [3][W];
    int           held  [3][W];
    logic [W-1:0] m_out [3];
    logic [W-1:0] m_rise[3];
    logic [W-1:0] m_fall[3];
    logic [W-1:0] m_long[3];
    logic [W-1:0] m_any [3];

    function automatic logic [W-1:0] raw_in(int k);
        case (k)
            0:       return b0.in;
            1:       return b1.in;
            default: return b2.in;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pipe[k][0] = init_cfg[k];
            pipe[k][1] = init_cfg[k];
            for (int j = 0; j < 8; j++) hist[k][j] = init_cfg[k];
            for (int c = 0; c < W; c++) begin
                since[k][c] = 1000;
                held[k][c]  = -1;
            end
            m_out[k]  = init_cfg[k];
            m_rise[k] = '0;
            m_fall[k] = '0;
            m_long[k] = '0;
            m_any[k]  = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [W-1:0] sync;
            logic [W-1:0] prev;
            sync       = pipe[k][1];
            pipe[k][1] = pipe[k][0];
            pipe[k][0] = raw_in(k);
            for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = sync;
            prev       = m_out[k];
            m_rise[k]  = '0;
            m_fall[k]  = '0;
            m_long[k]  = '0;
            for (int c = 0; c < W; c++) begin
                bit take;
                take = 1'b0;
                if (since[k][c] < 1000) since[k][c]++;
                if (m_cfg[k] == 0) begin
                    take = 1'b1;
                    for (int j = 0; j < d_cfg[k]; j++)
                        if (hist[k][j][c] == prev[c]) take = 1'b0;
                end else begin
                    take = (sync[c] != prev[c]) && (since[k][c] >= d_cfg[k]);
                end
                if (take) begin
                    m_out[k][c] = ~prev[c];
                    if (sync[c]) m_rise[k][c] = 1'b1;
                    else         m_fall[k][c] = 1'b1;
                    since[k][c] = 0;
                    held[k][c]  = sync[c] ? 0 : -1;
                end else if (prev[c] && held[k][c] >= 0) begin
                    held[k][c]++;
                    if (held[k][c] == LC) m_long[k][c] = LONG_EN;
                end
            end
            m_any[k] = {3'b000, |(m_rise[k] | m_fall[k])};
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else         model_step();
    end

    task automatic expect_eq(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(int k, logic [W-1:0] o, logic [W-1:0] r, logic [W-1:0] f,
                             logic [W-1:0] l, logic a);
        expect_eq($sformatf("u%0d.out", k),  o, m_out[k]);
        expect_eq($sformatf("u%0d.rise", k), r, m_rise[k]);
        expect_eq($sformatf("u%0d.fall", k), f, m_fall[k]);
        expect_eq($sformatf("u%0d.long", k), l, m_long[k]);
        expect_eq($sformatf("u%0d.any_change", k), {3'b000, a}, m_any[k]);
    endtask

    always @(negedge clk) begin
        check_dut(0, b0.out, b0.rise, b0.fall, b0.long, b0.any_change);
        check_dut(1, b1.out, b1.rise, b1.fall, b1.long, b1.any_change);
        check_dut(2, b2.out, b2.rise, b2.fall, b2.long, b2.any_change);
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [11:0] vecs  [8] = '{12'h53A, 12'hACA, 12'h000, 12'hFF5, 12'h369, 12'h369, 12'hC1F, 12'h005};
    int          holds [8] = '{2, 5, 1, 6, 3, 4, 2, 7};

    initial begin
        b0.in = 4'b0101;
        b1.in = 4'b0000;
        b2.in = 4'b0000;
        #1 resetn = 1'b0;
        step(3);
        expect_eq("lit_rst_out0", b0.out, 4'b0101);
        expect_eq("lit_rst_rise0", b0.rise, 4'b0000);
        resetn = 1'b1;

        // edge numbering: the next rising edge is edge 1
        b0.in = 4'b0111;
        b1.in = 4'b0010;
        b2.in = 4'b1111;
        step(1);
        b1.in = 4'b0000;
        step(2);
        expect_eq("lit_m1_rise_e3", b1.rise, 4'b0010);
        expect_eq("lit_m1_any_e3", {3'b000, b1.any_change}, 4'b0001);
        expect_eq("lit_d1_rise_e3", b2.rise, 4'b1111);
        expect_eq("lit_d1_any_e3", {3'b000, b2.any_change}, 4'b0001);
        step(2);
        expect_eq("lit_m0_rise_e5", b0.rise, 4'b0000);
        expect_eq("lit_m0_out_e5", b0.out, 4'b0101);
        step(1);
        expect_eq("lit_m0_rise_e6", b0.rise, 4'b0010);
        expect_eq("lit_m0_any_e6", {3'b000, b0.any_change}, 4'b0001);
        expect_eq("lit_m0_out_e6", b0.out, 4'b0111);
        step(1);
        expect_eq("lit_m1_fall_e7", b1.fall, 4'b0010);
        expect_eq("lit_m0_rise_e7", b0.rise, 4'b0000);

        // 3-cycle glitch is filtered, 4-cycle one is accepted
        b0.in = 4'b0101;
        step(3);
        b0.in = 4'b0111;
        step(8);
        expect_eq("lit_glitch3_out", b0.out, 4'b0111);
        b0.in = 4'b0101;
        step(4);
        b0.in = 4'b0111;
        step(12);

        // toggles during lockout that end at the accepted level leave no extra edge
        b1.in = 4'b0100;
        step(1);
        b1.in = 4'b0000;
        step(1);
        b1.in = 4'b0100;
        step(10);
        expect_eq("lit_lockout_out", b1.out, 4'b0100);
        b1.in = 4'b0000;
        step(8);

        for (int v = 0; v < 8; v++) begin
            b0.in = vecs[v][3:0];
            b1.in = vecs[v][7:4];
            b2.in = vecs[v][11:8];
            step(holds[v]);
        end
        b0.in = 4'b0101;
        b1.in = 4'b0000;
        b2.in = 4'b0000;
        step(12);

        // long press on u0 channel 3
        b0.in = 4'b1101;
        step(6);
        expect_eq("lit_lp_rise", b0.rise, 4'b1000);
        step(8);
        expect_eq("lit_lp_long", b0.long, LONG_EN ? 4'b1000 : 4'b0000);
        step(1);
        expect_eq("lit_lp_long_once", b0.long, 4'b0000);
        step(12);
        b0.in = 4'b0101;
        step(8);
        b0.in = 4'b1101;
        step(20);
        b0.in = 4'b0101;
        step(8);

        // reset in the middle of a hold
        b0.in = 4'b1101;
        step(10);
        resetn = 1'b0;
        #1;
        expect_eq("lit_midrst_out", b0.out, 4'b0101);
        expect_eq("lit_midrst_long", b0.long, 4'b0000);
        expect_eq("lit_midrst_rise", b0.rise, 4'b0000);
        step(2);
        resetn = 1'b1;
        step(24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
